ref_filter_pipe: RTL and testbench

//  Parametrised, pipelined intra reference-sample smoothing stage for NxN prediction

---
 rtl/ref_filter_pkg.sv | 13 +
 rtl/ref_strong_decide.sv | 24 ++
 rtl/ref_filter_pipe.sv | 119 +++++++++++
 tb/tb_ref_filter_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_filter_pkg.sv
// Shared definitions for the reference-sample smoothing pipeline.
package ref_filter_pkg;

    localparam logic [1:0] MODE_BYP  = 2'd0;
    localparam logic [1:0] MODE_121  = 2'd1;
    localparam logic [1:0] MODE_AUTO = 2'd2;

    // Flatness threshold for the strong-smoothing decision.
    function automatic int unsigned f_strong_thr(input int unsigned bd);
        return 32'd1 << (bd - 32'd5);
    endfunction

endpackage

// File: rtl/ref_strong_decide.sv
// Flatness test for one side of the reference array: |corner + end - 2*mid| < threshold.
module ref_strong_decide
    import ref_filter_pkg::*;
#(
    parameter int unsigned BD = 8
) (
    input  logic [BD-1:0] i_corner,
    input  logic [BD-1:0] i_end,
    input  logic [BD-1:0] i_mid,
    output logic          o_flag
);

    localparam int unsigned W = BD + 3;
    localparam logic [W-1:0] THR = W'(f_strong_thr(BD));

    logic signed [W-1:0] w_diff;
    logic        [W-1:0] w_abs;

    assign w_diff = $signed({3'b000, i_corner}) + $signed({3'b000, i_end})
                  - $signed({2'b00, i_mid, 1'b0});
    assign w_abs  = w_diff[W-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign o_flag = (w_abs < THR);

endmodule

// File: rtl/ref_filter_pipe.sv
// Pipelined intra reference-sample smoothing: bypass, [1 2 1]/4, or strong bilinear (N == 32).
// S1 captures ref/mode/strong decision, S2 holds the filtered result; valid/ready on both sides.
module ref_filter_pipe
    import ref_filter_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned BD   = 8,
    parameter int unsigned LOGM = 4
) (
    input  logic                    CLK1,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [1:0]              IN_MODE,
    input  logic [(4*N+1)*BD-1:0]   IN_REF,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [(4*N+1)*BD-1:0]   OUT_REF,
    output logic                    OUT_STRONG
);

    localparam int unsigned M  = 2 * N;
    localparam int unsigned W  = (2 * M + 1) * BD;
    localparam int unsigned SW = BD + LOGM + 1;

    if (LOGM != $clog2(2 * N)) begin : g_bad_logm
        $error("ref_filter_pipe: LOGM must equal $clog2(2*N)");
    end

    logic         w_top_ok;
    logic         w_left_ok;
    logic         w_strong_in;
    logic         w_s2_free;
    logic         w_use_121;
    logic [W-1:0] w_filt;

    logic         r_s1_valid;
    logic [1:0]   r_s1_mode;
    logic         r_s1_strong;
    logic [W-1:0] r_s1_ref;
    logic         r_s2_valid;
    logic         r_s2_strong;
    logic [W-1:0] r_s2_ref;

    ref_strong_decide #(.BD(BD)) u_top_decide (
        .i_corner (IN_REF[M*BD +: BD]),
        .i_end    (IN_REF[2*M*BD +: BD]),
        .i_mid    (IN_REF[3*N*BD +: BD]),
        .o_flag   (w_top_ok)
    );

    ref_strong_decide #(.BD(BD)) u_left_decide (
        .i_corner (IN_REF[M*BD +: BD]),
        .i_end    (IN_REF[0 +: BD]),
        .i_mid    (IN_REF[N*BD +: BD]),
        .o_flag   (w_left_ok)
    );

    // Strong smoothing only exists for 32x32 blocks in auto mode.
    assign w_strong_in = (N == 32) && (IN_MODE == MODE_AUTO) && w_top_ok && w_left_ok;

    assign w_s2_free = !r_s2_valid || OUT_READY;
    assign IN_READY  = !r_s1_valid || w_s2_free;
    assign w_use_121 = (r_s1_mode == MODE_121) || ((r_s1_mode == MODE_AUTO) && !r_s1_strong);

    for (genvar k = 0; k <= 2 * M; k++) begin : g_tap
        if (k == 0 || k == 2 * M) begin : g_end
            assign w_filt[k*BD +: BD] = r_s1_ref[k*BD +: BD];
        end else begin : g_mid
            // Corner weight falls linearly from M at the corner towards the array ends.
            localparam int unsigned WC = (k < M) ? k : 2 * M - k;
            localparam int unsigned EI = (k < M) ? 0 : 2 * M;
            logic [BD+1:0] w_sum121;
            logic [SW-1:0] w_sum_str;

            assign w_sum121  = {2'b00, r_s1_ref[(k-1)*BD +: BD]}
                             + {1'b0, r_s1_ref[k*BD +: BD], 1'b0}
                             + {2'b00, r_s1_ref[(k+1)*BD +: BD]} + (BD+2)'(2);
            assign w_sum_str = SW'(WC) * SW'(r_s1_ref[M*BD +: BD])
                             + SW'(M - WC) * SW'(r_s1_ref[EI*BD +: BD]) + SW'(M / 2);
            assign w_filt[k*BD +: BD] = r_s1_strong ? BD'(w_sum_str >> LOGM)
                                      : w_use_121   ? BD'(w_sum121 >> 2)
                                      :               r_s1_ref[k*BD +: BD];
        end
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= MODE_BYP;
            r_s1_strong <= 1'b0;
            r_s1_ref    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_strong <= 1'b0;
            r_s2_ref    <= '0;
        end else begin
            if (IN_READY) begin
                r_s1_valid <= IN_VALID;
                if (IN_VALID) begin
                    r_s1_mode   <= IN_MODE;
                    r_s1_strong <= w_strong_in;
                    r_s1_ref    <= IN_REF;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_strong <= r_s1_strong;
                    r_s2_ref    <= w_filt;
                end
            end
        end
    end

    assign OUT_VALID  = r_s2_valid;
    assign OUT_STRONG = r_s2_strong;
    assign OUT_REF    = r_s2_ref;

endmodule

// File: tb/tb_ref_filter_pipe.sv
// Bench for ref_filter_pipe: four instances (N/BD = 4/8, 8/10, 16/10, 32/8) share handshake
// controls; a queue scoreboard fed by an arithmetic reference model checks every output.
module tb_ref_filter_pipe;

    localparam int MAXW = 1056;

    typedef struct packed {
        logic [3:0][MAXW-1:0] r;
        logic [3:0]           s;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 out_ready;
    logic [1:0]           in_mode;
    logic [3:0][MAXW-1:0] in_ref;
    wire  [3:0]           in_ready;
    wire  [3:0]           out_valid;
    wire  [3:0]           out_strong;
    wire  [MAXW-1:0]      out_ref [4];

    int                   errors = 0;
    int                   checks = 0;
    int                   n_acc = 0;
    int                   n_out = 0;
    bit                   got_out;
    logic [3:0][MAXW-1:0] last_out;
    logic [3:0]           last_str;
    txn_t                 sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GN  = 4 << g;
        localparam int GBD = (g == 1 || g == 2) ? 10 : 8;
        localparam int GW  = (4 * GN + 1) * GBD;
        wire [GW-1:0] w_out;
        ref_filter_pipe #(.N(GN), .BD(GBD), .LOGM($clog2(2 * GN))) u_dut (
            .CLK1       (clk),
            .RST        (rst),
            .IN_VALID   (in_valid),
            .IN_READY   (in_ready[g]),
            .IN_MODE    (in_mode),
            .IN_REF     (in_ref[g][GW-1:0]),
            .OUT_VALID  (out_valid[g]),
            .OUT_READY  (out_ready),
            .OUT_REF    (w_out),
            .OUT_STRONG (out_strong[g])
        );
        assign out_ref[g] = MAXW'(w_out);
    end

    function automatic int n_of(input int g);
        return 4 << g;
    endfunction

    function automatic int bd_of(input int g);
        return (g == 1 || g == 2) ? 10 : 8;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference model: unpack samples, apply the smoothing rules with integer arithmetic, repack.
    function automatic void model(input logic [MAXW-1:0] r, input int g, input logic [1:0] mode,
                                  output logic [MAXW-1:0] o, output logic s);
        int n, bd, m, t, j;
        int v[129];
        int w[129];
        logic [MAXW-1:0] tmp;
        n  = n_of(g);
        bd = bd_of(g);
        m  = 2 * n;
        t  = 1 << (bd - 5);
        for (int k = 0; k <= 2 * m; k++) begin
            tmp  = r >> (k * bd);
            v[k] = int'(tmp[11:0]) & ((1 << bd) - 1);
        end
        s = (mode == 2'd2) && (n == 32) && (iabs(v[m] + v[2*m] - 2 * v[3*n]) < t)
            && (iabs(v[m] + v[0] - 2 * v[n]) < t);
        for (int k = 0; k <= 2 * m; k++) begin
            w[k] = v[k];
            if (k > 0 && k < 2 * m) begin
                if (s) begin
                    if (k > m) begin
                        j    = k - m;
                        w[k] = ((m - j) * v[m] + j * v[2*m] + m / 2) / m;
                    end else if (k < m) begin
                        j    = m - k;
                        w[k] = ((m - j) * v[m] + j * v[0] + m / 2) / m;
                    end
                end else if (mode == 2'd1 || mode == 2'd2) begin
                    w[k] = (v[k-1] + 2 * v[k] + v[k+1] + 2) / 4;
                end
            end
        end
        o = '0;
        for (int k = 0; k <= 2 * m; k++) begin
            tmp       = '0;
            tmp[31:0] = w[k];
            o         = o | (tmp << (k * bd));
        end
    endfunction

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [MAXW-1:0] got,
                           input logic [MAXW-1:0] exp);
        int b;
        b = 0;
        for (int i = MAXW - 1; i >= 0; i--) if (got[i] !== exp[i]) b = i;
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: first differing bit %0d got %h expected %h", tag, b,
                   got[b +: 16], exp[b +: 16]);
        end
    endtask

    task automatic rand_refs();
        logic [MAXW-1:0] v;
        logic [MAXW-1:0] ones;
        ones = '1;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < MAXW; i += 32) v[i +: 32] = $urandom;
            in_ref[g] = v & ~(ones << ((4 * n_of(g) + 1) * bd_of(g)));
        end
    endtask

    // Near-linear ramps on the 32x32 instance so the strong path is exercised often.
    task automatic smooth_ref32();
        int a, c, b, x;
        a = $urandom_range(0, 255);
        c = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        in_ref[3] = '0;
        for (int k = 0; k <= 128; k++) begin
            x = (k < 64) ? a + ((c - a) * k) / 64 : c + ((b - c) * (k - 64)) / 64;
            x = x + $urandom_range(0, 2);
            if (x > 255) x = 255;
            in_ref[3][k*8 +: 8] = x[7:0];
        end
    endtask

    // One clock: sample handshakes away from the edge, update scoreboard, then cross the edge.
    task automatic tick();
        txn_t t;
        #1;
        got_out = 1'b0;
        if (!rst && out_valid[0] && out_ready) begin
            got_out = 1'b1;
            n_out++;
            for (int g = 0; g < 4; g++) begin
                last_out[g] = out_ref[g];
                last_str[g] = out_strong[g];
            end
            if (sb.size() == 0) begin
                chk_int("sb_unexpected_output", 1, 0);
            end else begin
                t = sb.pop_front();
                for (int g = 0; g < 4; g++) begin
                    chk_vec($sformatf("sb_ref_i%0d", g), out_ref[g], t.r[g]);
                    chk_int($sformatf("sb_strong_i%0d", g), int'(out_strong[g]), int'(t.s[g]));
                end
            end
        end
        if (!rst && in_valid && in_ready[0]) begin
            n_acc++;
            for (int g = 0; g < 4; g++) model(in_ref[g], g, in_mode, t.r[g], t.s[g]);
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one_txn(input logic [1:0] mode, input string tag);
        int prev;
        prev     = n_acc;
        in_valid = 1'b1;
        in_mode  = mode;
        tick();
        in_valid = 1'b0;
        chk_int({tag, "_accept"}, n_acc - prev, 1);
        chk_int({tag, "_lat_s1"}, int'(out_valid[0]), 0);
        tick();
        chk_int({tag, "_lat_s2"}, int'(out_valid[0]), 1);
        tick();
        chk_int({tag, "_out"}, int'(got_out), 1);
    endtask

    initial begin
        logic [MAXW-1:0] exp;
        logic [MAXW-1:0] saved;
        int base, bout, prev;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0; in_ref = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk_int($sformatf("rst_out_valid_i%0d", g), int'(out_valid[g]), 0);
            chk_int($sformatf("rst_out_strong_i%0d", g), int'(out_strong[g]), 0);
            chk_vec($sformatf("rst_out_ref_i%0d", g), out_ref[g], '0);
            chk_int($sformatf("rst_in_ready_i%0d", g), int'(in_ready[g]), 1);
        end
        out_ready = 1'b1;

        // Impulse through [1 2 1] on the 4x4 instance.
        rand_refs();
        in_ref[0] = '0;
        in_ref[0][8*8 +: 8] = 8'd200;
        one_txn(2'd1, "impulse");
        exp = '0;
        exp[7*8 +: 8] = 8'd50;
        exp[8*8 +: 8] = 8'd100;
        exp[9*8 +: 8] = 8'd50;
        chk_vec("impulse_ref", last_out[0], exp);
        chk_int("impulse_strong", int'(last_str[0]), 0);

        // Bypass modes are bit-exact.
        for (int md = 0; md < 4; md += 3) begin
            rand_refs();
            saved = in_ref[0];
            one_txn(md[1:0], $sformatf("bypass_m%0d", md));
            chk_vec($sformatf("bypass_m%0d_ref", md), last_out[0], saved);
        end

        // Strong smoothing on the 32x32 instance, then a failing top flatness test.
        rand_refs();
        in_ref[3] = '0;
        in_ref[3][96*8 +: 8]  = 8'd64;
        in_ref[3][128*8 +: 8] = 8'd128;
        one_txn(2'd2, "strong");
        exp = '0;
        for (int j = 1; j < 64; j++) exp[(64+j)*8 +: 8] = 8'(2 * j);
        exp[128*8 +: 8] = 8'd128;
        chk_int("strong_flag", int'(last_str[3]), 1);
        chk_vec("strong_ref", last_out[3], exp);
        in_ref[3][96*8 +: 8] = 8'd80;
        one_txn(2'd2, "fallback");
        chk_int("fallback_flag", int'(last_str[3]), 0);
        chk_int("fallback_s96", int'(last_out[3][96*8 +: 8]), 40);
        chk_int("fallback_s95", int'(last_out[3][95*8 +: 8]), 20);
        chk_int("fallback_s127", int'(last_out[3][127*8 +: 8]), 32);

        // Backpressure: four back-to-back requests against a stalled output.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1;
        rand_refs();
        base = n_acc; bout = n_out;
        for (int i = 0; i < 6; i++) begin
            prev = n_acc;
            tick();
            if (n_acc != prev) rand_refs();
            if (n_acc - base == 4) in_valid = 1'b0;
        end
        #1;
        chk_int("bp_accepts_stalled", n_acc - base, 2);
        chk_int("bp_in_ready_low", int'(in_ready[0]), 0);
        chk_int("bp_no_output", n_out - bout, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !(n_acc - base == 4 && sb.size() == 0); i++) begin
            prev = n_acc;
            tick();
            if (n_acc != prev) rand_refs();
            if (n_acc - base == 4) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk_int("bp_outputs", n_out - bout, 4);
        chk_int("bp_drained", sb.size(), 0);

        // Reset with two transactions in flight.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd2;
        rand_refs();
        tick();
        rand_refs();
        tick();
        in_valid = 1'b0;
        chk_int("flush_inflight", int'(out_valid[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk_int("flush_out_valid", int'(out_valid[0]), 0);
        chk_int("flush_in_ready", int'(in_ready[0]), 1);
        out_ready = 1'b1;
        rand_refs();
        one_txn(2'd1, "post_flush");

        // Random stream, all modes and sizes, random valid/ready.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            rand_refs();
            if ($urandom_range(0, 1) == 1) smooth_ref32();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk_int("random_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
